// File: rtl/max_pool2x2_stream.sv
// Streaming 2x2 / stride-2 FP32 max-pool with optional ReLU.
// It keeps one row of pair maxima; there is no frame storage.
module max_pool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_SIZE    = 98,
  parameter int RELU_EN    = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int OUT_SIZE = IN_SIZE / 2;
  localparam int CW       = $clog2(IN_SIZE);
  localparam int KW       = (CW > 1) ? CW - 1 : 1;
  localparam int DEPTH    = 1 << KW;
  localparam bit ODD      = (IN_SIZE % 2) == 1;

  localparam logic [CW-1:0]         LAST     = CW'(IN_SIZE - 1);
  localparam logic [CW-1:0]         OUT_LAST = CW'(OUT_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] SIGN     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Monotonic integer key: a larger key means a larger float.
  function automatic logic [DATA_WIDTH-1:0] fpKey(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? ~x : (x | SIGN);
  endfunction

  function automatic logic isZero(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-2:0] == '0;
  endfunction

  // Operand a is the earlier one. It is kept on a tie, and the two zeros count as a tie.
  function automatic logic [DATA_WIDTH-1:0] fpMax(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic w_bWins;
    w_bWins = (fpKey(b) > fpKey(a)) && !(isZero(a) && isZero(b));
    return w_bWins ? b : a;
  endfunction

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_rowBuf [0:DEPTH-1];

  logic [KW-1:0]         w_k;
  logic                  w_inWindow;
  logic                  w_take;
  logic                  w_holdWe;
  logic                  w_bufWe;
  logic                  w_outWe;
  logic                  w_lastWin;
  logic [DATA_WIDTH-1:0] w_pairMax;
  logic [DATA_WIDTH-1:0] w_winMax;
  logic [DATA_WIDTH-1:0] w_pooled;

  assign w_k        = KW'(r_col >> 1);
  assign w_inWindow = !(ODD && ((r_col == LAST) || (r_row == LAST)));
  assign w_take     = valid_in && w_inWindow;
  assign w_holdWe   = w_take && !r_col[0];
  assign w_bufWe    = w_take && r_col[0] && !r_row[0];
  assign w_outWe    = w_take && r_col[0] && r_row[0];
  assign w_lastWin  = ((r_col >> 1) == OUT_LAST) && ((r_row >> 1) == OUT_LAST);
  assign w_pairMax  = fpMax(r_hold, data_in);
  assign w_winMax   = fpMax(r_rowBuf[w_k], w_pairMax);
  assign w_pooled   = ((RELU_EN != 0) && w_winMax[DATA_WIDTH-1]) ? '0 : w_winMax;

  // Raster position. In an odd-sized frame the last row and column are counted but never pooled.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_hold     <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= w_outWe;
      frame_done <= w_outWe && w_lastWin;
      if (w_holdWe) r_hold <= data_in;
      if (w_outWe)  data_out <= w_pooled;
    end
  end

  // The even row writes every entry before the odd row reads it, so the buffer needs no reset.
  always_ff @(posedge Clk) begin
    if (w_bufWe) r_rowBuf[w_k] <= w_pairMax;
  end

endmodule
